// File: rtl/fifo_rd_stream_if.sv
// Bus bundle between the FIFO read adapter, the upstream FIFO read port and the stream consumer.
// The master modport is the adapter's view; the slave modport is the FIFO-plus-consumer side.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    output fifo_rd_en,
    input  fifo_data_out,
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    output fifo_empty,
    input  fifo_rd_en,
    output fifo_data_out,
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for a one-cycle-latency FIFO: prefetches into a 3-entry buffer and
// presents the words as a valid/ready stream at one word per clock.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  output logic [1:0]             level,
  fifo_rd_stream_if.master       bus
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            pending;
  logic                  rd_en;
  logic                  valid;
  logic                  capture;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] entry [3];
  logic [DATA_WIDTH-1:0] head;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every read in flight so a returning word always has room.
  assign pending = {1'b0, occ_q} + {2'b0, inflight_q};

  always_comb begin
    rd_en    = rst_n && !bus.fifo_empty && !flush && (pending < 3'd3);
    valid    = (occ_q != 2'd0) && !flush;
    capture  = inflight_q && !flush;
    transfer = valid && bus.m_ready;

    occ_d      = occ_q + {1'b0, capture} - {1'b0, transfer};
    inflight_d = rd_en;
    wr_ptr_d   = capture  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = transfer ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (flush) begin
      occ_d    = 2'd0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] word_q, word_d;

      always_comb begin
        word_d = word_q;
        if (capture && (wr_ptr_q == 2'(gi))) begin
          word_d = bus.fifo_data_out;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign entry[gi] = word_q;
    end
  endgenerate

  always_comb begin
    head = entry[0];
    case (rd_ptr_q)
      2'd1:    head = entry[1];
      2'd2:    head = entry[2];
      default: head = entry[0];
    endcase
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = head;
  assign level          = occ_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: behavioural one-cycle-latency FIFO upstream, scoreboarded stream sink downstream.
module tb_fifo_rd_stream;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] level;
  logic       wr_en;
  logic [7:0] wr_data;

  fifo_rd_stream_if #(.DATA_WIDTH(8)) ifc ();

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .level (level),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO model: read data valid the cycle after an accepted read.
  logic [7:0] fq [$];
  int         rd_cnt = 0;
  always @(posedge clk) begin
    if (ifc.fifo_rd_en && !ifc.fifo_empty) begin
      ifc.fifo_data_out <= fq.pop_front();
      rd_cnt <= rd_cnt + 1;
    end
    if (wr_en) fq.push_back(wr_data);
    ifc.fifo_empty <= (fq.size() == 0);
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
  endtask

  // One clock: sink scoreboard and hold-stability check mid-cycle, then advance to next negedge.
  task automatic cycle();
    #1;
    if (hold_pending && !flush) begin
      check("hold_valid", {31'b0, ifc.m_valid}, 1);
      check("hold_data", {24'b0, ifc.m_data}, {24'b0, hold_data});
    end
    if (ifc.m_valid && ifc.m_ready) begin
      if (exp_q.size() == 0) check("stream_extra", exp_q.size(), 1);
      else check("stream_data", {24'b0, ifc.m_data}, {24'b0, exp_q.pop_front()});
    end
    hold_pending = ifc.m_valid && !ifc.m_ready;
    hold_data    = ifc.m_data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0]  t1_valid;
    logic [7:0]  t1_rd;
    logic [15:0] t5_wr;
    logic [15:0] t5_valid;
    int          base;
    int          n;

    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    ifc.m_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", {31'b0, ifc.m_valid}, 0);
    check("rst_data", {24'b0, ifc.m_data}, 0);
    check("rst_level", {30'b0, level}, 0);
    check("rst_rd_en", {31'b0, ifc.fifo_rd_en}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: ready high, four words, 2-cycle latency then one per cycle
    ifc.m_ready = 1'b1;
    t1_valid = 8'b0111_1000;
    t1_rd    = 8'b0001_1110;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) push_word(8'hA1);
      if (c == 1) push_word(8'hB2);
      if (c == 2) push_word(8'hC3);
      if (c == 3) push_word(8'hD4);
      #1;
      check($sformatf("t1_valid_c%0d", c), {31'b0, ifc.m_valid}, {31'b0, t1_valid[c]});
      check($sformatf("t1_rd_en_c%0d", c), {31'b0, ifc.fifo_rd_en}, {31'b0, t1_rd[c]});
      check("t1_level_le1", {31'b0, level <= 2'd1}, 1);
      cycle();
    end
    check("t1_all_out", exp_q.size(), 0);

    // Test 2: backpressure with 8 words queued
    ifc.m_ready = 1'b0;
    base = rd_cnt;
    for (int c = 0; c < 8; c++) begin
      push_word(8'h10 + 8'(c));
      cycle();
    end
    repeat (4) cycle();
    check("t2_reads", rd_cnt - base, 3);
    check("t2_level", {30'b0, level}, 3);
    check("t2_rd_en", {31'b0, ifc.fifo_rd_en}, 0);
    check("t2_valid", {31'b0, ifc.m_valid}, 1);
    ifc.m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("t2_contig_valid", {31'b0, ifc.m_valid}, 1);
      cycle();
    end
    check("t2_all_out", exp_q.size(), 0);
    repeat (2) cycle();

    // Test 3: ready toggling every cycle over 20 random words
    for (int c = 0; c < 20; c++) begin
      push_word(8'($urandom_range(0, 255)));
      ifc.m_ready = c[0];
      cycle();
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      ifc.m_ready = ~ifc.m_ready;
      cycle();
      n++;
    end
    check("t3_all_out", exp_q.size(), 0);
    ifc.m_ready = 1'b1;
    repeat (3) cycle();

    // Test 4: flush right after a read accepted at level 2
    ifc.m_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      push_word(8'h50 + 8'(c));
      cycle();
      if (level == 2'd2) break;
    end
    n = 0;
    while (level != 2'd2 && n < 20) begin
      cycle();
      n++;
    end
    check("t4_level2", {30'b0, level}, 2);
    flush = 1'b1;
    #1;
    check("t4_flush_rd_en", {31'b0, ifc.fifo_rd_en}, 0);
    check("t4_flush_valid", {31'b0, ifc.m_valid}, 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    cycle();
    flush = 1'b0;
    check("t4_level_after", {30'b0, level}, 0);
    ifc.m_ready = 1'b1;
    drain(40);
    repeat (3) cycle();

    // Test 5: FIFO runs dry mid-stream, then refills
    t5_wr    = 16'b0000_0011_0000_0111;
    t5_valid = 16'b0001_1000_0011_1000;
    for (int c = 0; c < 16; c++) begin
      if (t5_wr[c]) push_word(8'h70 + 8'(c));
      #1;
      check($sformatf("t5_valid_c%0d", c), {31'b0, ifc.m_valid}, {31'b0, t5_valid[c]});
      check("t5_rd_when_empty", {31'b0, ifc.fifo_rd_en && ifc.fifo_empty}, 0);
      cycle();
    end
    check("t5_all_out", exp_q.size(), 0);
    check("t5_level_idle", {30'b0, level}, 0);

    // Test 6: asynchronous reset with a full buffer
    ifc.m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      push_word(8'h90 + 8'(c));
      cycle();
    end
    n = 0;
    while (level != 2'd3 && n < 10) begin
      cycle();
      n++;
    end
    check("t6_level3", {30'b0, level}, 3);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, ifc.m_valid}, 0);
    check("t6_rst_level", {30'b0, level}, 0);
    check("t6_rst_rd_en", {31'b0, ifc.fifo_rd_en}, 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    base = rd_cnt;
    @(negedge clk);
    @(negedge clk);
    check("t6_no_read_in_rst", rd_cnt - base, 0);
    rst_n = 1'b1;
    hold_pending = 1'b0;
    ifc.m_ready = 1'b1;
    drain(20);
    repeat (3) cycle();
    check("t6_level_end", {30'b0, level}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side adapter placed directly downstream of sync_fifo_ptr.
- Drives the FIFO's rd_en, empty and data_out interface and captures the returned words into a 3-entry output buffer.
- Presents the words as a valid/ready stream to the consumer.
- Sustains one word per clock with m_ready held high, and has no combinational path from m_ready to fifo_rd_en.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data.

Ports:
clk            input   1           system clock, all logic on rising edge
rst_n          input   1           asynchronous active-low reset
fifo_empty     input   1           empty flag from upstream FIFO
fifo_rd_en     output  1           read request to upstream FIFO
fifo_data_out  input   DATA_WIDTH  FIFO read data, valid 1 cycle after an accepted read
flush          input   1           synchronous clear of buffered and in-flight words
m_data         output  DATA_WIDTH  stream data, head of buffer
m_valid        output  1           stream valid
m_ready        input   1           stream ready from consumer
level          output  2           buffered word count, 0..3

Behaviour:
- Reset (rst_n low, asynchronous), all forced low or zero:
  - Outputs: m_valid=0, m_data=0, level=0, fifo_rd_en=0.
  - Internal state: occupancy occ=0, inflight=0, buffer read/write pointers=0.
- FIFO read contract:
  - A read is accepted when fifo_rd_en=1 and fifo_empty=0 at a rising edge.
  - The word appears on fifo_data_out in the following cycle.
- Issue rule: fifo_rd_en = !fifo_empty && !flush && (occ + inflight < 3).
  - Uses only registered state plus fifo_empty and flush.
  - inflight <= fifo_rd_en (this is 1 iff a read was accepted last edge).
- Capture:
  - When inflight=1 and flush=0, fifo_data_out is written at the buffer write pointer.
  - The write pointer increments mod 3.
- Stream output:
  - m_valid = (occ != 0) && !flush.
  - m_data = buffer entry at the read pointer; it is 0 after reset until the first capture.
  - A transfer occurs when m_valid && m_ready; the read pointer increments mod 3.
  - m_data/m_valid hold stable while m_valid=1 and m_ready=0.
- Occupancy update per edge: occ <= occ + capture - transfer.
  - Simultaneous capture and transfer leaves occ unchanged.
  - occ never exceeds 3: the issue rule guarantees a free slot for every in-flight word.
  - level = occ.
- Throughput: in steady state occ=1, inflight=1, so one word is issued, captured and transferred every cycle.
- Latency:
  - A word written into a previously empty FIFO is issued the cycle fifo_empty falls.
  - It is visible on m_valid 2 cycles later: 1 cycle to capture, 1 cycle for occ to register.
- Backpressure:
  - m_ready=0 lets occ rise to 3; fifo_rd_en then drops to 0 and FIFO contents are held.
  - On m_ready reassertion, reads resume with no word lost or duplicated.
- flush (synchronous, 1 cycle):
  - In the flush cycle, fifo_rd_en=0 and m_valid=0.
  - A word arriving that cycle (inflight=1) is discarded.
  - At the edge: occ, inflight and pointers are cleared to 0.
  - Words still inside the FIFO are not affected.
- Reset mid-operation: buffered and in-flight words are lost; the FIFO is not re-read for them.
- Ordering: output order equals FIFO read order. Pointer wrap 2->0 must preserve order.

Test Plan:
- Ready held high; write A1,B2,C3,D4 into the FIFO -> stream outputs A1,B2,C3,D4 in order, one per cycle after the initial 2-cycle latency; level never exceeds 1.
- m_ready=0 with 8 words in the FIFO -> exactly 3 reads issued, level=3, fifo_rd_en=0 thereafter. Raise m_ready -> all 8 words delivered in order, contiguous valid.
- Toggle m_ready each cycle over 20 random words -> no loss or duplication; pointer wrap exercised at least 5 times; m_data stable whenever valid&&!ready.
- Assert flush the cycle after a read accepted with level=2 -> in-flight word and both buffered words dropped; next stream word is the next FIFO entry; level=0 after the flush edge.
- FIFO goes empty mid-stream -> m_valid drops after the last word; fifo_rd_en=0 while fifo_empty=1; no spurious capture.
- Deassert rst_n asynchronously with level=3 -> m_valid, level and fifo_rd_en go 0 immediately without waiting for a clock edge; normal operation resumes after release.
